// File: rtl/unum_alu_acc_if.sv
// unum_alu_acc_if: run/config/operand/result bundle between the Versat controller and unum_alu_acc.
interface unum_alu_acc_if #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32,
    parameter int LEN_W   = 16
);
    logic               running;
    logic               run;
    logic               done;
    logic [2:0]         opcode;
    logic [LEN_W-1:0]   len;
    logic [DELAY_W-1:0] delay0;
    logic [DATA_W-1:0]  in0;
    logic [DATA_W-1:0]  in1;
    logic [DATA_W-1:0]  out0;
    modport master (output running, run, opcode, len, delay0, in0, in1, input done, out0);
    modport slave (input running, run, opcode, len, delay0, in0, in1, output done, out0);
endinterface

// File: rtl/unum_alu_acc.sv
// unum_alu_acc: Versat ALU/accumulator with start delay, per-run sample count and PIPE-stage output.
// Define UNUM_ALU_SAT_EN to saturate ADD/SUB/ACC to the signed limits instead of wrapping.
module unum_alu_acc #(
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 32,
    parameter int LEN_W   = 16,
    parameter int PIPE    = 1
) (
    input logic           clk,
    input logic           rst,
    unum_alu_acc_if.slave bus
);
`ifdef UNUM_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int PIPE_W = $clog2(PIPE + 1);
    localparam int CNT_W0 = DELAY_W > LEN_W ? DELAY_W : LEN_W;
    localparam int CNT_W  = CNT_W0 > PIPE_W ? CNT_W0 : PIPE_W;
    localparam logic signed [DATA_W+1:0] SMAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+1:0] SMIN = {3'b111, {(DATA_W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, DRAIN} state_t;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] pipe_q [PIPE];
    logic [DATA_W-1:0] pipe_d [PIPE];
    logic signed [DATA_W+1:0] a, b, c;
    logic [DATA_W-1:0] acc_next, stage0;
    logic              cnt_one;
    // Operands are widened by two bits so a three-term sum never overflows before clamping.
    function automatic logic [DATA_W-1:0] fit(input logic signed [DATA_W+1:0] x);
        return (SAT && x > SMAX) ? SMAX[DATA_W-1:0] :
               (SAT && x < SMIN) ? SMIN[DATA_W-1:0] : x[DATA_W-1:0];
    endfunction
    always_comb begin
        a        = {{2{bus.in0[DATA_W-1]}}, bus.in0};
        b        = {{2{bus.in1[DATA_W-1]}}, bus.in1};
        c        = first_q ? '0 : {{2{acc_q[DATA_W-1]}}, acc_q};
        acc_next = fit(a + b + c);
        stage0   = op_q == 3'd0 ? fit(a + b) :
                   op_q == 3'd1 ? fit(a - b) :
                   op_q == 3'd2 ? (a < b ? bus.in0 : bus.in1) :
                   op_q == 3'd3 ? (a < b ? bus.in1 : bus.in0) :
                   op_q == 3'd4 ? (state_q == ACTIVE ? acc_next : acc_q) : bus.in0;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        len_d   = len_q;
        first_d = first_q;
        acc_d   = acc_q;
        pipe_d  = pipe_q;
        cnt_one = cnt_q == CNT_W'(1);
        if (bus.running) begin
            pipe_d[0] = stage0;
            for (int i = 1; i < PIPE; i++) pipe_d[i] = pipe_q[i-1];
            case (state_q)
                DELAY: begin
                    state_d = cnt_one ? (len_q == '0 ? DRAIN : ACTIVE) : DELAY;
                    cnt_d   = cnt_one ? (len_q == '0 ? CNT_W'(PIPE) : CNT_W'(len_q)) : cnt_q - CNT_W'(1);
                end
                ACTIVE: begin
                    acc_d   = op_q == 3'd4 ? acc_next : acc_q;
                    first_d = 1'b0;
                    state_d = cnt_one ? DRAIN : ACTIVE;
                    cnt_d   = cnt_one ? CNT_W'(PIPE) : cnt_q - CNT_W'(1);
                end
                DRAIN: begin
                    state_d = cnt_one ? IDLE : DRAIN;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
        // A new run overrides whatever the current run was about to do, even while stalled.
        if (bus.run) begin
            op_d    = bus.opcode;
            len_d   = bus.len;
            first_d = 1'b1;
            state_d = bus.delay0 != '0 ? DELAY : bus.len == '0 ? DRAIN : ACTIVE;
            cnt_d   = bus.delay0 != '0 ? CNT_W'(bus.delay0) : bus.len == '0 ? CNT_W'(PIPE) : CNT_W'(bus.len);
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            len_q   <= '0;
            first_q <= 1'b0;
            acc_q   <= '0;
            pipe_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            len_q   <= len_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            pipe_q  <= pipe_d;
        end
    end
    assign bus.done = state_q == IDLE;
    assign bus.out0 = pipe_q[PIPE-1];
endmodule

// File: tb/tb_unum_alu_acc.sv
// tb_unum_alu_acc: randomized and directed stimulus against a run-timeline reference model.
module tb_unum_alu_acc;
    localparam int DW   = 8;
    localparam int PIPE = 3;
`ifdef UNUM_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n;
    unum_alu_acc_if #(.DATA_W(DW), .DELAY_W(4), .LEN_W(4)) bus();
    unum_alu_acc #(.DATA_W(DW), .DELAY_W(4), .LEN_W(4), .PIPE(PIPE)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Reference: a run is delay0 idle cycles, then len sample cycles, then PIPE drain cycles.
    int m_pipe [PIPE];
    int m_acc, m_op, m_t, m_d, m_l;
    bit m_first, m_busy;
    int ma, mb, ms0;
    bit m_act;
    function automatic int fit(input int s);
        if (SAT && s > (1 << (DW-1)) - 1) return (1 << (DW-1)) - 1;
        if (SAT && s < -(1 << (DW-1))) return 1 << (DW-1);
        return s & ((1 << DW) - 1);
    endfunction
    function automatic int sx(input int v);
        return v >= (1 << (DW-1)) ? v - (1 << DW) : v;
    endfunction
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIPE; i++) m_pipe[i] = 0;
            m_acc = 0; m_op = 0; m_t = 0; m_d = 0; m_l = 0; m_first = 0; m_busy = 0;
        end else begin
            if (bus.running) begin
                m_act = m_busy && m_t >= m_d && m_t < m_d + m_l;
                ma = sx(int'(bus.in0));
                mb = sx(int'(bus.in1));
                case (m_op)
                    0: ms0 = fit(ma + mb);
                    1: ms0 = fit(ma - mb);
                    2: ms0 = ma < mb ? int'(bus.in0) : int'(bus.in1);
                    3: ms0 = ma < mb ? int'(bus.in1) : int'(bus.in0);
                    4: begin
                        if (m_act) begin
                            m_acc = fit((m_first ? 0 : sx(m_acc)) + ma + mb);
                            m_first = 0;
                        end
                        ms0 = m_acc;
                    end
                    default: ms0 = int'(bus.in0);
                endcase
                for (int i = PIPE - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
                m_pipe[0] = ms0;
                if (m_busy) begin
                    m_t++;
                    if (m_t == m_d + m_l + PIPE) m_busy = 0;
                end
            end
            if (bus.run) begin
                m_op = int'(bus.opcode); m_d = int'(bus.delay0); m_l = int'(bus.len);
                m_t = 0; m_busy = 1; m_first = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        check("out0_model", 32'(bus.out0), 32'(m_pipe[PIPE-1]));
        check("done_model", 32'(bus.done), 32'(!m_busy));
    end

    task automatic tick(input bit rn, input bit rr, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.running = rn; bus.run = rr; bus.in0 = a; bus.in1 = b;
        @(posedge clk); #1;
    endtask
    task automatic start(input logic [2:0] op, input logic [3:0] ln, input logic [3:0] dl,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.opcode = op; bus.len = ln; bus.delay0 = dl;
        tick(1'b1, 1'b1, a, b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.running = 0; bus.run = 0; bus.opcode = 0; bus.len = 0; bus.delay0 = 0; bus.in0 = 0; bus.in1 = 0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_out0", 32'(bus.out0), 0);
        check("reset_done", 32'(bus.done), 1);
        rst = 1'b1;
        repeat (4) tick(1, 0, 8'd0, 8'd0);
        // ADD streams while idle: 200 + 100 wraps to 44, three cycles later.
        tick(1, 0, 8'd200, 8'd100);
        tick(1, 0, 8'd0, 8'd0);
        check("add_lat2", 32'(bus.out0), 0);
        tick(1, 0, 8'd0, 8'd0);
        check("add_lat3", 32'(bus.out0), 44);
        tick(1, 0, 8'd100, 8'd50);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd0, 8'd0);
        check("add_sat", 32'(bus.out0), SAT ? 127 : 150);
        start(3'd3, 4'd0, 4'd0, 8'd0, 8'd0);
        tick(1, 0, 8'hFF, 8'd1);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd0, 8'd0);
        check("max_signed", 32'(bus.out0), 1);
        start(3'd2, 4'd0, 4'd0, 8'd0, 8'd0);
        tick(1, 0, 8'hFF, 8'd1);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd0, 8'd0);
        check("min_signed", 32'(bus.out0), 255);
        // ACC, delay0=2, len=4: sums 2,5,9,14; done high 2+4+PIPE cycles after run.
        start(3'd4, 4'd4, 4'd2, 8'd0, 8'd0);
        check("acc_done_fall", 32'(bus.done), 0);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd1, 8'd1);
        tick(1, 0, 8'd2, 8'd1);
        tick(1, 0, 8'd3, 8'd1);
        check("acc_sum1", 32'(bus.out0), 2);
        tick(1, 0, 8'd4, 8'd1);
        check("acc_sum2", 32'(bus.out0), 5);
        tick(1, 0, 8'd0, 8'd0);
        check("acc_sum3", 32'(bus.out0), 9);
        tick(1, 0, 8'd0, 8'd0);
        check("acc_sum4", 32'(bus.out0), 14);
        check("acc_done_low", 32'(bus.done), 0);
        tick(1, 0, 8'd0, 8'd0);
        check("acc_done_rise", 32'(bus.done), 1);
        // Same run with a 5-cycle stall after two samples.
        start(3'd4, 4'd4, 4'd2, 8'd0, 8'd0);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd0, 8'd0);
        tick(1, 0, 8'd1, 8'd1);
        tick(1, 0, 8'd2, 8'd1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 8'($urandom), 8'($urandom));
            check("stall_hold", 32'(bus.out0), 14);
        end
        tick(1, 0, 8'd3, 8'd1);
        tick(1, 0, 8'd4, 8'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            tick(1, 0, 8'd0, 8'd0);
            n++;
        end
        check("stall_done_cycles", 32'(11 + n), 14);
        check("stall_final_sum", 32'(bus.out0), 14);
        // Restart on the last sample of a len=2 run.
        start(3'd4, 4'd2, 4'd0, 8'd0, 8'd0);
        tick(1, 0, 8'd10, 8'd0);
        start(3'd4, 4'd2, 4'd0, 8'd20, 8'd0);
        tick(1, 0, 8'd1, 8'd1);
        tick(1, 0, 8'd1, 8'd2);
        check("restart_old_sum", 32'(bus.out0), 30);
        tick(1, 0, 8'd0, 8'd0);
        check("restart_first", 32'(bus.out0), 2);
        tick(1, 0, 8'd0, 8'd0);
        check("restart_second", 32'(bus.out0), 5);
        start(3'd0, 4'd0, 4'd0, 8'd0, 8'd0);
        check("zero_done_low", 32'(bus.done), 0);
        n = 0;
        while (!bus.done && n < 40) begin
            tick(1, 0, 8'd0, 8'd0);
            n++;
        end
        check("zero_len_drain", 32'(n), PIPE);
        // Asynchronous reset in the middle of ACTIVE.
        start(3'd4, 4'd8, 4'd0, 8'd5, 8'd5);
        tick(1, 0, 8'd5, 8'd5);
        tick(1, 0, 8'd5, 8'd5);
        #2 rst = 1'b0;
        #1;
        check("rst_async_out0", 32'(bus.out0), 0);
        check("rst_async_done", 32'(bus.done), 1);
        @(posedge clk); #1 rst = 1'b1;
        tick(1, 0, 8'd7, 8'd9);
        check("idle_after_reset", 32'(bus.done), 1);
        for (int i = 0; i < 1500; i++) begin
            bus.opcode = 3'($urandom_range(0, 7));
            bus.len    = 4'($urandom_range(0, 15));
            bus.delay0 = 4'($urandom_range(0, 5));
            tick($urandom_range(0, 9) != 0,
                 bus.done ? $urandom_range(0, 3) == 0 : $urandom_range(0, 39) == 0,
                 8'($urandom), 8'($urandom));
        end
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unum_alu_acc.md
Name: unum_alu_acc

Overview:
- Parametrised successor to the single-cycle adder functional unit for the Versat datapath.
- Selects an ALU operation per run (add, sub, signed min/max, accumulate).
- Provides a configurable output pipeline depth and a start-delay counter.
- Counts samples per run and reports done to the Versat controller only after the last result has left the pipeline.

Parameters:
- DATA_W, 32, operand/result width.
- DELAY_W, 32, width of start-delay config.
- LEN_W, 16, width of sample-count config.
- PIPE, 1, output latency in cycles (>=1); declared to Versat as versat_latency.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- running  in  1  accelerator running; all internal state advances only while high
- run  in  1  one-cycle start pulse; latches config, restarts unit
- done  out  1  unit idle/finished
- opcode  in  3  0 ADD, 1 SUB (in0-in1), 2 MIN signed, 3 MAX signed, 4 ACC, 5-7 PASS in0
- len  in  LEN_W  samples to process per run
- delay0  in  DELAY_W  cycles from run to first valid sample
- in0  in  DATA_W  operand A
- in1  in  DATA_W  operand B
- out0  out  DATA_W  result, PIPE cycles after operands

Behaviour:
- Reset (rst=0, async):
  - FSM=IDLE, done=1, out0=0.
  - All pipeline stages, counters and accumulator cleared.
- Config capture: opcode, len and delay0 are latched on run; later changes are ignored until the next run.
- FSM states:
  - IDLE: done=1. run -> DELAY when delay0!=0, else ACTIVE (or DRAIN when len==0).
  - DELAY: decrement delay counter each running cycle. At 1 -> ACTIVE (or DRAIN when len==0).
  - ACTIVE: one sample per running cycle; decrement sample counter. On the last sample -> DRAIN.
  - DRAIN: count PIPE cycles, then -> IDLE with done=1.
  - done=0 in DELAY, ACTIVE and DRAIN.
- Datapath:
  - Stage-0 result is computed combinationally from in0/in1 and opcode, then shifted through PIPE registers to out0.
  - The pipeline shifts every running cycle, including in IDLE and DELAY. Non-ACC ops therefore stream continuously; out0 = f(in0,in1) delayed by PIPE running cycles.
  - ADD/SUB wrap modulo 2^DATA_W.
  - MIN/MAX compare operands as two's complement.
- ACC mode:
  - First ACTIVE sample: acc = in0+in1.
  - Later samples: acc = acc+in0+in1, wrapping.
  - Stage-0 value is acc_next, so out0 shows the running sum.
  - Outside ACTIVE, acc holds and stage-0 presents the held acc.
- Stall: running=0 freezes FSM, counters, acc and pipeline. out0 and done hold.
- run priority: run in any state, including the cycle of the last sample, aborts the current run and restarts with the new config. The accumulator restarts on the next first sample. The pipeline is not flushed.
- run with running=0: still latches config and restarts the FSM (run takes priority over the stall). Counting begins once running=1.
- Counter rules:
  - delay0=0 and len=0 -> DRAIN immediately.
  - Maximum len = 2^LEN_W-1; no wrap of the sample counter.
- Reset mid-run: immediate return to IDLE, done=1, out0=0.

Optional Feature:
- UNUM_ALU_SAT_EN defined: ADD, SUB and ACC saturate to the signed limits 2^(DATA_W-1)-1 and -2^(DATA_W-1) instead of wrapping. In ACC, saturation applies to the full three-term sum.
- Undefined: all arithmetic wraps.
- MIN, MAX and PASS are unaffected either way.

Test Plan:
- Reset: rst low mid-ACTIVE -> out0=0 and done=1 asynchronously. After release, FSM is IDLE.
- ADD, PIPE=3, DATA_W=8: in0=200, in1=100, running=1 -> out0=44 exactly 3 cycles later. With UNUM_ALU_SAT_EN, repeat with in0=100, in1=50 -> out0=127.
- MAX/MIN signed: in0=0xFFFFFFFF, in1=1 -> MAX gives 1, MIN gives 0xFFFFFFFF.
- ACC, delay0=2, len=4, PIPE=1, in0=k, in1=1 for samples k=1..4:
  - Sums out0 = 2, 5, 9, 14.
  - done falls the cycle after run and rises 1 cycle after the last sum (drain).
  - Total run->done = 2+4+1 cycles.
- Stall: drop running for 5 cycles mid-ACTIVE -> out0 and counters frozen; the final sum and done timing shift by exactly 5 cycles.
- Restart/edge cases:
  - run on the last ACTIVE sample with len=2 -> new run; acc restarts from the first sample.
  - delay0=0, len=0 -> done back high after PIPE cycles.
